video_timing_gen: RTL and testbench

Raster timing and pixel-source stage feeding the TMDS transmitter top. It generates `hsync`/`vsync`/`de` and a 24-bit `rgb` word on the pixel clock for a parameterised raster, with default 640x480@60, 25.175 MHz. The `rgb` word is either an internal colour-bar pattern or an external pixel source addressed through `x_o`/`y_o`. All outputs are registered, so they connect directly to the encoder inputs, which expect registered data.

---
 rtl/video_timing_gen_if.sv | 16 +
 rtl/video_timing_gen.sv | 136 +++++++++++++
 tb/tb_video_timing_gen.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/video_timing_gen_if.sv
// Pixel/timing bundle between the raster generator, its external pixel source and the TMDS encoder.
interface video_timing_gen_if;
  logic        en;
  logic [23:0] pix_rgb;
  logic [23:0] rgb;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [11:0] x_o;
  logic [11:0] y_o;
  logic        sof;
  logic        busy;

  modport master (output en, pix_rgb, input rgb, hsync, vsync, de, x_o, y_o, sof, busy);
  modport slave  (input en, pix_rgb, output rgb, hsync, vsync, de, x_o, y_o, sof, busy);
endinterface

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered hsync/vsync/de/rgb/sof for the TMDS encoder.
// Define VTG_PATTERN_EN to source rgb from internal 8-bar colour pattern instead of pix_rgb.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
) (
  input  logic               pclk,
  input  logic               rstin,
  video_timing_gen_if.slave  vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  logic [11:0] h_cnt, v_cnt;
  logic [23:0] rgb_q, pix;
  logic        hsync_q, vsync_q, de_q, sof_q, busy_q;
  logic        h_last, f_last, active, hs_on, vs_on;

  always_comb begin
    h_last = (h_cnt == H_LAST);
    f_last = h_last && (v_cnt == V_LAST);
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_on  = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_on  = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

`ifdef VTG_PATTERN_EN
  localparam logic [11:0] BAR_W = 12'(H_ACTIVE / 8);
  logic [2:0] bar;
  logic       unused_pix;
  assign unused_pix = ^vif.pix_rgb;

  always_comb begin
    bar = 3'(h_cnt / BAR_W);
    case (bar)
      3'd0:    pix = 24'hFFFFFF;
      3'd1:    pix = 24'hFFFF00;
      3'd2:    pix = 24'h00FFFF;
      3'd3:    pix = 24'h00FF00;
      3'd4:    pix = 24'hFF00FF;
      3'd5:    pix = 24'hFF0000;
      3'd6:    pix = 24'h0000FF;
      default: pix = 24'h000000;
    endcase
  end
`else
  // External source answers x_o/y_o combinationally; sampled on the edge that registers de.
  assign pix = vif.pix_rgb;
`endif

  always_ff @(posedge pclk or posedge rstin) begin
    if (rstin) begin
      state   <= IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      busy_q  <= 1'b0;
      de_q    <= 1'b0;
      rgb_q   <= '0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      sof_q   <= 1'b0;
    end else begin
      if (state == IDLE) begin
        de_q    <= 1'b0;
        rgb_q   <= '0;
        hsync_q <= ~H_POL;
        vsync_q <= ~V_POL;
        sof_q   <= 1'b0;
      end else begin
        de_q    <= active;
        rgb_q   <= active ? pix : '0;
        hsync_q <= hs_on ? H_POL : ~H_POL;
        vsync_q <= vs_on ? V_POL : ~V_POL;
        sof_q   <= (h_cnt == '0) && (v_cnt == '0);
      end

      case (state)
        IDLE: if (vif.en) begin
          state  <= RUN;
          busy_q <= 1'b1;
        end
        RUN, DRAIN: begin
          // Only the last pixel of a frame may stop the raster; anything else keeps timing intact.
          if (f_last && !vif.en) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
          end else begin
            state <= vif.en ? RUN : DRAIN;
            h_cnt <= h_last ? '0 : h_cnt + 12'd1;
            if (h_last) v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 12'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          h_cnt  <= '0;
          v_cnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk)
    assert (H_TOTAL <= 4095 && V_TOTAL <= 4095)
      else $error("video_timing_gen: raster totals exceed 12-bit counters");

  assign vif.rgb   = rgb_q;
  assign vif.hsync = hsync_q;
  assign vif.vsync = vsync_q;
  assign vif.de    = de_q;
  assign vif.sof   = sof_q;
  assign vif.busy  = busy_q;
  assign vif.x_o   = h_cnt;
  assign vif.y_o   = v_cnt;
endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized self-checking bench for video_timing_gen on a reduced raster plus a positive-polarity instance.
module tb_video_timing_gen;
  localparam int HA = 32, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int P_HT = 24, P_VT = 10, P_HS = 3, P_VS = 2;
  localparam logic [52:0] IDLE_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'h0, 12'h0, 12'h0};
`ifdef VTG_PATTERN_EN
  localparam logic [23:0] PROBE_RGB = 24'h00FFFF;
`else
  localparam logic [23:0] PROBE_RGB = 24'h0A035A;
`endif

  logic pclk = 1'b0;
  logic rstin = 1'b1;
  int n_tests = 0, n_fail = 0;
  int m_h = 0, m_v = 0;
  bit m_run = 1'b0;
  bit probe_hit = 1'b0;
  logic [52:0] exp_vec = '0;

  always #5 pclk = ~pclk;

  video_timing_gen_if vif ();
  video_timing_gen_if vif1 ();
  assign vif.pix_rgb  = {vif.x_o[7:0], vif.y_o[7:0], 8'h5A};
  assign vif1.pix_rgb = '0;

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                     .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                     .H_POL(1'b0), .V_POL(1'b0))
    dut (.pclk(pclk), .rstin(rstin), .vif(vif));

  video_timing_gen #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(P_HS), .H_BP(3),
                     .V_ACTIVE(6), .V_FP(1), .V_SYNC(P_VS), .V_BP(1),
                     .H_POL(1'b1), .V_POL(1'b1))
    dut_pol (.pclk(pclk), .rstin(rstin), .vif(vif1));

  function automatic logic [52:0] obs();
    return {vif.busy, vif.sof, vif.de, vif.hsync, vif.vsync, vif.rgb, vif.x_o, vif.y_o};
  endfunction

  // One pclk edge of the reference raster: outputs follow the pre-edge position, then position moves.
  task automatic tick(input logic e);
    logic ede, ehs, evs, esof;
    logic [23:0] ergb;
    vif.en = e;
    @(posedge pclk);
    probe_hit = m_run && (m_h == 10) && (m_v == 3);
    if (m_run) begin
      ede  = (m_h < HA) && (m_v < VA);
      ehs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
      evs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
      esof = (m_h == 0) && (m_v == 0);
`ifdef VTG_PATTERN_EN
      case (m_h / (HA / 8))
        0: ergb = 24'hFFFFFF;
        1: ergb = 24'hFFFF00;
        2: ergb = 24'h00FFFF;
        3: ergb = 24'h00FF00;
        4: ergb = 24'hFF00FF;
        5: ergb = 24'hFF0000;
        6: ergb = 24'h0000FF;
        default: ergb = 24'h000000;
      endcase
`else
      begin
        logic [11:0] hh, vv;
        hh = 12'(m_h);
        vv = 12'(m_v);
        ergb = {hh[7:0], vv[7:0], 8'h5A};
      end
`endif
      if (!ede) ergb = '0;
    end else begin
      ede = 1'b0; ehs = 1'b1; evs = 1'b1; esof = 1'b0; ergb = '0;
    end
    if (!m_run) m_run = e;
    else if (m_h == HT - 1 && m_v == VT - 1 && !e) begin
      m_run = 1'b0; m_h = 0; m_v = 0;
    end else begin
      m_h++;
      if (m_h == HT) begin m_h = 0; m_v = (m_v + 1) % VT; end
    end
    exp_vec = {m_run, esof, ede, ehs, evs, ergb, 12'(m_h), 12'(m_v)};
    #1;
  endtask

  task automatic test_reset();
    rstin = 1'b1; vif.en = 1'b0; vif1.en = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    n_tests++;
    if (obs() !== IDLE_VEC) begin n_fail++; $display("FAIL reset_state: got %h exp %h", obs(), IDLE_VEC); end
    @(negedge pclk);
    rstin = 1'b0;
    m_run = 1'b0; m_h = 0; m_v = 0;
  endtask

  task automatic test_frames();
    int sof_t[$];
    int de_cnt = 0, de_runs = 0, hs_fall = -1, hs_len = 0, vs_fall = -1, vs_cnt = 0;
    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_de = 1'b0;
    for (int t = 0; t < 2 * FRAME + 5; t++) begin
      tick(1'b1);
      n_tests++;
      if (obs() !== exp_vec) begin n_fail++; $display("FAIL frames t=%0d: got %h exp %h", t, obs(), exp_vec); end
      if (probe_hit) begin
        n_tests++;
        if (vif.rgb !== PROBE_RGB) begin n_fail++; $display("FAIL probe_x10_y3: got %h exp %h", vif.rgb, PROBE_RGB); end
      end
      if (vif.sof) sof_t.push_back(t);
      if (sof_t.size() == 1) begin
        if (vif.de) de_cnt++;
        if (vif.de && !prev_de) de_runs++;
        if (!vif.hsync && prev_hs && hs_fall < 0) hs_fall = t - sof_t[0];
        if (!vif.hsync && (t - sof_t[0]) < HT) hs_len++;
        if (!vif.vsync && prev_vs && vs_fall < 0) vs_fall = t - sof_t[0];
        if (!vif.vsync) vs_cnt++;
      end
      prev_hs = vif.hsync; prev_vs = vif.vsync; prev_de = vif.de;
    end
    n_tests++;
    if (sof_t.size() != 3) begin n_fail++; $display("FAIL sof_count: got %0d exp 3", sof_t.size()); end
    else begin
      n_tests++;
      if (sof_t[0] != 1) begin n_fail++; $display("FAIL first_de_latency: got %0d exp 1", sof_t[0]); end
      n_tests++;
      if (sof_t[1] - sof_t[0] != FRAME) begin n_fail++; $display("FAIL sof_period: got %0d exp %0d", sof_t[1] - sof_t[0], FRAME); end
    end
    n_tests++;
    if (de_cnt != HA * VA) begin n_fail++; $display("FAIL de_per_frame: got %0d exp %0d", de_cnt, HA * VA); end
    n_tests++;
    if (de_runs != VA) begin n_fail++; $display("FAIL de_runs: got %0d exp %0d", de_runs, VA); end
    n_tests++;
    if (hs_fall != HA + HF) begin n_fail++; $display("FAIL hsync_start: got %0d exp %0d", hs_fall, HA + HF); end
    n_tests++;
    if (hs_len != HS) begin n_fail++; $display("FAIL hsync_width: got %0d exp %0d", hs_len, HS); end
    n_tests++;
    if (vs_fall != (VA + VF) * HT) begin n_fail++; $display("FAIL vsync_start: got %0d exp %0d", vs_fall, (VA + VF) * HT); end
    n_tests++;
    if (vs_cnt != VS * HT) begin n_fail++; $display("FAIL vsync_width: got %0d exp %0d", vs_cnt, VS * HT); end
  endtask

  task automatic test_en_drop();
    int n = 0, drain_busy = 0;
    while (!(m_run && m_v == 5 && m_h == 0) && n < 2 * FRAME) begin
      tick(1'b1); n++;
      n_tests++;
      if (obs() !== exp_vec) begin n_fail++; $display("FAIL drop_lead: got %h exp %h", obs(), exp_vec); end
    end
    n = 0;
    while (m_run && n < 2 * FRAME) begin
      tick(1'b0); n++;
      n_tests++;
      if (obs() !== exp_vec) begin n_fail++; $display("FAIL drop_drain: got %h exp %h", obs(), exp_vec); end
      if (vif.busy) drain_busy++;
    end
    n_tests++;
    if (drain_busy != FRAME - 5 * HT - 1) begin
      n_fail++; $display("FAIL drain_length: got %0d exp %0d", drain_busy, FRAME - 5 * HT - 1);
    end
    repeat (5) tick(1'b0);
    n_tests++;
    if (vif.busy !== 1'b0 || vif.de !== 1'b0) begin n_fail++; $display("FAIL idle_after_drain: busy %b de %b exp 0 0", vif.busy, vif.de); end
  endtask

  task automatic test_en_glitch();
    int t = 0, s0 = -1, s1 = -1, drop = 0;
    bit d4 = 1'b0, d8 = 1'b0;
    logic e;
    while (s1 < 0 && t < 3 * FRAME) begin
      e = 1'b1;
      if (!d4 && m_run && m_v == 4 && m_h == 0) begin d4 = 1'b1; e = 1'b0; end
      if (!d8 && m_run && m_v == 8 && m_h == 0) begin d8 = 1'b1; drop = 7; end
      if (drop > 0) begin drop--; e = 1'b0; end
      tick(e);
      n_tests++;
      if (obs() !== exp_vec) begin n_fail++; $display("FAIL glitch t=%0d: got %h exp %h", t, obs(), exp_vec); end
      if (vif.sof) begin if (s0 < 0) s0 = t; else s1 = t; end
      t++;
    end
    n_tests++;
    if (s1 < 0 || s1 - s0 != FRAME) begin n_fail++; $display("FAIL glitch_sof_period: got %0d exp %0d", s1 - s0, FRAME); end
  endtask

  task automatic test_random();
    int lo = 1;
    for (int t = 0; t < 4000; t++) begin
      if (t % 500 == 0) lo = (lo == 1) ? 7 : 1;
      tick(logic'($urandom_range(0, 9) >= lo));
      n_tests++;
      if (obs() !== exp_vec) begin n_fail++; $display("FAIL random t=%0d: got %h exp %h", t, obs(), exp_vec); end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0, s = -1;
    while (!(m_run && m_h == 20 && m_v == 6) && n < 3 * FRAME) begin
      tick(1'b1); n++;
      n_tests++;
      if (obs() !== exp_vec) begin n_fail++; $display("FAIL rstmid_lead: got %h exp %h", obs(), exp_vec); end
    end
    rstin = 1'b1;
    #2;
    n_tests++;
    if (obs() !== IDLE_VEC) begin n_fail++; $display("FAIL rstmid_idle: got %h exp %h", obs(), IDLE_VEC); end
    m_run = 1'b0; m_h = 0; m_v = 0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rstin = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(1'b1);
      n_tests++;
      if (obs() !== exp_vec) begin n_fail++; $display("FAIL rstmid_restart: got %h exp %h", obs(), exp_vec); end
      if (vif.sof && s < 0) s = t;
    end
    n_tests++;
    if (s != 1) begin n_fail++; $display("FAIL rstmid_sof: got %0d exp 1", s); end
  endtask

  task automatic test_polarity();
    int t = 0, hs_hi = 0, vs_hi = 0, run = 0, maxrun = 0;
    vif.en = 1'b0;
    vif1.en = 1'b1;
    while (vif1.sof !== 1'b1 && t < 10) begin @(posedge pclk); #1; t++; end
    n_tests++;
    if (vif1.sof !== 1'b1) begin n_fail++; $display("FAIL pol_sof: got %b exp 1", vif1.sof); end
    for (int i = 0; i < P_HT * P_VT; i++) begin
      if (vif1.hsync) begin hs_hi++; run++; if (run > maxrun) maxrun = run; end else run = 0;
      if (vif1.vsync) vs_hi++;
      @(posedge pclk); #1;
    end
    vif1.en = 1'b0;
    n_tests++;
    if (hs_hi != P_HS * P_VT) begin n_fail++; $display("FAIL pol_hsync_high: got %0d exp %0d", hs_hi, P_HS * P_VT); end
    n_tests++;
    if (maxrun != P_HS) begin n_fail++; $display("FAIL pol_hsync_width: got %0d exp %0d", maxrun, P_HS); end
    n_tests++;
    if (vs_hi != P_VS * P_HT) begin n_fail++; $display("FAIL pol_vsync_high: got %0d exp %0d", vs_hi, P_VS * P_HT); end
  endtask

  initial begin
    test_reset();
    test_frames();
    test_en_drop();
    test_en_glitch();
    test_random();
    test_reset_mid();
    test_polarity();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end
endmodule
